// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding, the hard-wired zero register index and the bubble NOP word.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    // addi x0, x0, 0 -- the word the datapath bubble muxes insert
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the D-stage sources and the
// destination of a load sitting in X.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       d_use1,
    input  logic       d_use2,
    input  logic [4:0] x_rd,
    input  logic       x_is_load,
    output logic       load_use
);

    logic match1_s;
    logic match2_s;

    assign match1_s = d_use1 && (d_rs1 == x_rd);
    assign match2_s = d_use2 && (d_rs2 == x_rd);
    // Writes to the zero register are discarded, so they can never feed D.
    assign load_use = x_is_load && (x_rd != REG_ZERO) && (match1_s || match2_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D, D/X, X/M latches and the PC, with a
// multdiv wait FSM and watchdog. Optional PIPE_CTRL_PERF_EN adds stall and
// flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 7
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        d_use1,
    input  logic        d_use2,
    input  logic [4:0]  x_rd,
    input  logic        x_is_load,
    input  logic        x_br_taken,
    input  logic        x_is_md,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        fd_flush,
    output logic        dx_we,
    output logic        dx_bubble,
    output logic        xm_we,
    output logic        xm_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MD_MAX_CYCLES);

    md_state_e          state_r;
    md_state_e          state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               wd_hit_s;
    logic               md_err_r;
    logic               load_use_s;

    hazard_detect u_hazard_detect (
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .d_use1    (d_use1),
        .d_use2    (d_use2),
        .x_rd      (x_rd),
        .x_is_load (x_is_load),
        .load_use  (load_use_s)
    );

    // Next-state, watchdog next value and zero-latency latch controls.
    always_comb begin
        pc_we        = 1'b1;
        fd_we        = 1'b1;
        fd_flush     = 1'b0;
        dx_we        = 1'b1;
        dx_bubble    = 1'b0;
        xm_we        = 1'b1;
        xm_bubble    = 1'b0;
        md_start     = 1'b0;
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wd_hit_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (x_is_md) begin
                    md_start     = 1'b1;
                    pc_we        = 1'b0;
                    fd_we        = 1'b0;
                    dx_we        = 1'b0;
                    xm_bubble    = 1'b1;
                    state_next_s = MD_WAIT;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (x_br_taken) begin
                    // The D instruction is squashed, so a load-use stall is moot.
                    fd_flush  = 1'b1;
                    dx_bubble = 1'b1;
                end else if (load_use_s) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_bubble = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            MD_WAIT: begin
                if (md_ready) begin
                    state_next_s = RUN;
                end else begin
                    pc_we      = 1'b0;
                    fd_we      = 1'b0;
                    dx_we      = 1'b0;
                    xm_bubble  = 1'b1;
                    cnt_next_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);
                    wd_hit_s   = (cnt_next_s >= CNT_LIMIT);
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // FSM state, watchdog counter and sticky watchdog error.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r  <= RUN;
            cnt_r    <= {CNT_W{1'b0}};
            md_err_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            md_err_r <= md_err_r | wd_hit_s;
        end
    end

    assign md_busy = (state_r == MD_WAIT);
    assign md_err  = md_err_r;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] PERF_SAT = 32'hFFFF_FFFF;
    localparam logic [31:0] PERF_ONE = 32'd1;

    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (!pc_we && (stall_cnt_r != PERF_SAT)) begin
                stall_cnt_r <= stall_cnt_r + PERF_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (fd_flush && (flush_cnt_r != PERF_SAT)) begin
                flush_cnt_r <= flush_cnt_r + PERF_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed pinned cases plus
// randomized traffic compared against a behavioural model every cycle.
module tb_pipe_hazard_ctrl;

    localparam int MDMAX = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] d_rs1 = 5'd0, d_rs2 = 5'd0, x_rd = 5'd0;
    logic       d_use1 = 1'b0, d_use2 = 1'b0, x_is_load = 1'b0;
    logic       x_br_taken = 1'b0, x_is_md = 1'b0, md_ready = 1'b0;
    logic       pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, xm_bubble;
    logic       md_start, md_busy, md_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.MD_MAX_CYCLES(MDMAX), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1),
        .d_use2(d_use2), .x_rd(x_rd), .x_is_load(x_is_load),
        .x_br_taken(x_br_taken), .x_is_md(x_is_md), .md_ready(md_ready),
        .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush), .dx_we(dx_we),
        .dx_bubble(dx_bubble), .xm_we(xm_we), .xm_bubble(xm_bubble),
        .md_start(md_start), .md_busy(md_busy), .md_err(md_err)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: is a multdiv outstanding, how long has it waited, has it overrun.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    bit          m_err  = 1'b0;
    longint      m_stall = 0;
    longint      m_flush = 0;

    logic        pin_en = 1'b0;
    logic [9:0]  pin_exp = 10'd0;
    string       pin_name = "";

    // Output vector order: pc_we fd_we fd_flush dx_we dx_bubble xm_we xm_bubble md_start md_busy md_err
    function automatic logic [9:0] exp_out(input bit busy, input bit err);
        bit hz;
        bit pc, fd, fl, dx, db, xm, xb, st;
        hz = x_is_load && (x_rd != 5'd0) &&
             ((d_use1 && d_rs1 == x_rd) || (d_use2 && d_rs2 == x_rd));
        {pc, fd, fl, dx, db, xm, xb, st} = 8'b1101_0100;
        if (busy && !md_ready) begin
            {pc, fd, dx, xb} = 4'b0001;
        end else if (!busy && x_is_md) begin
            {pc, fd, dx, xb, st} = 5'b00011;
        end else if (!busy && x_br_taken) begin
            {fl, db} = 2'b11;
        end else if (!busy && hz) begin
            {pc, fd, db} = 3'b001;
        end
        return {pc, fd, fl, dx, db, xm, xb, st, busy, err};
    endfunction

    // Model state advance, following the async reset like the design does.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_busy  <= 1'b0;
            m_wait  <= 0;
            m_err   <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            logic [9:0] e;
            e = exp_out(m_busy, m_err);
            if (!e[9]) m_stall <= m_stall + 1;
            if (e[7])  m_flush <= m_flush + 1;
            if (!m_busy) begin
                if (x_is_md) begin
                    m_busy <= 1'b1;
                    m_wait <= 0;
                end
            end else if (md_ready) begin
                m_busy <= 1'b0;
            end else begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= MDMAX) m_err <= 1'b1;
            end
        end
    end

    // Single compare process: model every cycle, pinned literal when set.
    always @(negedge clk) begin
        logic [9:0] act, mexp;
        act  = {pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, xm_bubble,
                md_start, md_busy, md_err};
        mexp = exp_out(m_busy, m_err);
        checks++;
        if (act !== mexp) begin
            errors++;
            $display("FAIL model t=%0t got=%b expected=%b", $time, act, mexp);
        end
        if (pin_en) begin
            checks++;
            if (act !== pin_exp) begin
                errors++;
                $display("FAIL %s t=%0t got=%b expected=%b", pin_name, $time, act, pin_exp);
            end
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush)) begin
            errors++;
            $display("FAIL perf t=%0t got=%0d/%0d expected=%0d/%0d", $time,
                     stall_cnt, flush_cnt, m_stall, m_flush);
        end
`endif
    end

    task automatic cyc(input logic rst, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic br,
                       input logic md, input logic rdy,
                       input logic pon, input logic [9:0] pval, input string nm);
        @(posedge clk);
        #1;
        clr = ~rst; x_is_load = ld; x_rd = rd; d_rs1 = rs1; d_rs2 = rs2;
        d_use1 = u1; d_use2 = u2; x_br_taken = br; x_is_md = md; md_ready = rdy;
        pin_en = pon; pin_exp = pval; pin_name = nm;
    endtask

    task automatic idle(input logic md, input logic rdy, input logic pon,
                        input logic [9:0] pval, input string nm);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, md, rdy, pon, pval, nm);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'b1101010000, "in_reset");
        idle(1'b0, 1'b0, 1'b1, 10'b1101010000, "after_reset");
        // Load-use and its x_rd=0 / branch-override variants
        cyc(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'b0001110000, "load_use");
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'b1101010000, "rd_zero");
        cyc(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'b1111110000, "br_over_lu");
        cyc(1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'b1101010000, "rs1_unused");
        // Multdiv: start, 4 waits, release into a back-to-back start
        idle(1'b1, 1'b1, 1'b1, 10'b0000011100, "md_start");
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b1, 10'b0000011010, "md_wait");
        idle(1'b1, 1'b1, 1'b1, 10'b1101010010, "md_release");
        idle(1'b1, 1'b0, 1'b1, 10'b0000011100, "md_restart");
        idle(1'b0, 1'b0, 1'b1, 10'b0000011010, "md_wait2");
        idle(1'b0, 1'b1, 1'b1, 10'b1101010010, "md_release2");
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'b1111110000, "ready_in_run");
        // Watchdog: error appears after the 8th unanswered wait cycle
        idle(1'b1, 1'b0, 1'b1, 10'b0000011100, "wd_start");
        for (int i = 0; i < MDMAX; i++) idle(1'b1, 1'b0, 1'b1, 10'b0000011010, "wd_pre");
        idle(1'b1, 1'b0, 1'b1, 10'b0000011011, "wd_err");
        for (int i = 0; i < 20; i++) idle(1'b1, 1'b0, 1'b0, 10'd0, "");
        idle(1'b0, 1'b1, 1'b1, 10'b1101010011, "wd_release");
        idle(1'b0, 1'b0, 1'b1, 10'b1101010001, "wd_sticky");
        // Reset mid-wait clears busy and error immediately
        idle(1'b1, 1'b0, 1'b0, 10'd0, "");
        idle(1'b1, 1'b0, 1'b1, 10'b0000011011, "pre_rst");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'b1101010000, "rst_mid_wait");
        idle(1'b0, 1'b0, 1'b1, 10'b1101010000, "rst_released");
        // Three stalls and two flushes (perf build counts them)
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'b0001110000, "perf_stall");
        for (int i = 0; i < 2; i++)
            cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'b1111110000, "perf_flush");
`ifdef PIPE_CTRL_PERF_EN
        idle(1'b0, 1'b0, 1'b0, 10'd0, "");
        pin_en = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_literal got=%0d/%0d expected=3/2", stall_cnt, flush_cnt);
        end
`endif
        // Randomized traffic with small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 3) == 0), 1'b0, 10'd0, "");
        end
        idle(1'b0, 1'b1, 1'b0, 10'd0, "");
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline latches: F/D, D/X, X/M and the PC register.
- Generates per-latch write-enable, flush and bubble controls from hazard inputs supplied by the D and X stages.
- Tracks in-flight multiply/divide operations with a small FSM and a watchdog counter.
- Sits beside the datapath in the processor top; contains no datapath registers of its own.

Parameters:
- MD_MAX_CYCLES, 64: watchdog limit in cycles for one multdiv operation; exceeding it sets md_err.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > MD_MAX_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  asynchronous, active-low reset (0 = reset).
- d_rs1  in  5  D-stage source reg 1.
- d_rs2  in  5  D-stage source reg 2.
- d_use1  in  1  D instr reads rs1.
- d_use2  in  1  D instr reads rs2.
- x_rd  in  5  X-stage destination reg.
- x_is_load  in  1  X instr is lw.
- x_br_taken  in  1  X resolved taken branch/jump.
- x_is_md  in  1  X holds mult/div (level).
- md_ready  in  1  multdiv result valid this cycle.
- pc_we  out  1  PC write enable.
- fd_we  out  1  F/D latch write enable.
- fd_flush  out  1  F/D loads nop.
- dx_we  out  1  D/X write enable.
- dx_bubble  out  1  D/X loads nop.
- xm_we  out  1  X/M write enable.
- xm_bubble  out  1  X/M loads nop.
- md_start  out  1  one-cycle multdiv start pulse.
- md_busy  out  1  FSM in MD_WAIT.
- md_err  out  1  sticky watchdog error.

Behaviour:
- FSM states: RUN, MD_WAIT. Reset: state=RUN, watchdog counter=0, md_err=0.
- Control outputs are combinational from state and inputs; zero latency. State and counter update on posedge clk.
- Reset asserted mid-operation returns the FSM to RUN immediately (asynchronous).
- Default (no hazard): pc_we=fd_we=dx_we=xm_we=1; all flush/bubble=0; md_start=0.
- Load-use hazard:
  - Condition: x_is_load & x_rd!=0 & ((d_use1 & d_rs1==x_rd) | (d_use2 & d_rs2==x_rd)).
  - Response: pc_we=0, fd_we=0, dx_bubble=1.
  - x_rd=0 never stalls.
- Branch taken (RUN only):
  - Response: pc_we=1, fd_flush=1, dx_bubble=1.
  - Overrides load-use, since the D instruction is discarded.
- RUN with x_is_md:
  - md_start=1; pc_we=fd_we=dx_we=0; xm_we=1 with xm_bubble=1.
  - Next state MD_WAIT; counter cleared.
  - Branch and load-use are not evaluated: X holds a non-branch, non-load instruction.
- MD_WAIT, md_ready=0:
  - Same freeze as above, minus md_start.
  - Counter increments and saturates at 2^CNT_W-1.
  - When counter reaches MD_MAX_CYCLES, md_err is set (sticky until reset).
  - FSM stays in MD_WAIT; no forced release.
- MD_WAIT, md_ready=1:
  - All enables =1, xm_bubble=0 (X/M captures the result); next state RUN.
  - If the newly latched X instruction is also multdiv, RUN issues a fresh md_start on the next cycle.
- md_ready while in RUN is ignored.
- md_busy = (state==MD_WAIT).

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle pc_we=0.
  - flush_cnt increments each cycle fd_flush=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package: state encoding (RUN=1'b0, MD_WAIT=1'b1), REG_ZERO=5'd0, NOP encoding used by the bubble muxes.
- One natural sub-module, hazard_detect: combinational load-use comparator.
- FSM, watchdog and optional perf counters stay in the top module.

Test Plan:
- Reset: hold clr=0 mid-MD_WAIT, release -> md_busy=0, md_err=0, all enables=1.
- Load-use: x_is_load=1, x_rd=5, d_rs2=5, d_use2=1 -> pc_we=0, fd_we=0, dx_bubble=1 for that cycle. Repeat with x_rd=0 -> no stall.
- Branch plus load-use in the same cycle: x_br_taken=1 with the above hazard -> pc_we=1, fd_flush=1, dx_bubble=1.
- Multdiv sequence: x_is_md=1 with md_ready after 4 cycles.
  - md_start high for exactly 1 cycle.
  - Freeze for 5 cycles total.
  - Release cycle: xm_we=1, xm_bubble=0.
  - Back-to-back md restarts with a second md_start.
- Watchdog: MD_MAX_CYCLES=8, md_ready never asserted -> md_err=1 after 8 MD_WAIT cycles and stays 1 after md_ready.
- PERF (macro defined): 3 load-use stalls + 2 branches -> stall_cnt=3, flush_cnt=2.
